// File: rtl/branch_pred_ctrl_pkg.sv
// Shared definitions for the branch predictor: FSM states, 2-bit counter
// encodings and the PC field positions used to index/tag the table.
package branch_pred_ctrl_pkg;

    typedef enum logic {
        BP_ST_INIT = 1'b0,
        BP_ST_RUN  = 1'b1
    } bp_state_t;

    localparam logic [1:0] BP_CNT_SNT = 2'b00;
    localparam logic [1:0] BP_CNT_WNT = 2'b01;
    localparam logic [1:0] BP_CNT_WT  = 2'b10;
    localparam logic [1:0] BP_CNT_ST  = 2'b11;

    localparam int BP_PC_LSB = 2;

endpackage

// File: rtl/branch_pred_ctrl_bp_sat_cnt2.sv
// Combinational next value of a 2-bit saturating direction counter.
module bp_sat_cnt2
    import branch_pred_ctrl_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       taken,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (taken) begin
            if (cnt_in != BP_CNT_ST) cnt_out = cnt_in + 2'b01;
        end else begin
            if (cnt_in != BP_CNT_SNT) cnt_out = cnt_in - 2'b01;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Direct-mapped BHT/BTB: one-cycle IF lookup, retrained from EX resolution,
// with a post-reset sweep that invalidates every entry.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int         INDEX_W     = 6,
    parameter int         TAG_W       = 8,
    parameter logic [1:0] CNT_INIT_T  = 2'b10,
    parameter logic [1:0] CNT_INIT_NT = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_act_taken,
    input  logic [31:0] ex_target,
    output logic        busy
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_LSB = INDEX_W + BP_PC_LSB;
    localparam int TAG_MSB = INDEX_W + TAG_W + BP_PC_LSB - 1;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    bp_state_t          state_q, state_d;
    logic [INDEX_W-1:0] init_ptr_q, init_ptr_d;

    logic               pred_valid_q, pred_taken_q;
    logic [31:0]        pred_target_q;

    logic [INDEX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]   if_tag, ex_tag;
    logic               lk_taken, ex_hit;
    logic [1:0]         cnt_next;
    logic               unused_pc_bits;

    assign if_idx = if_pc[TAG_LSB-1:BP_PC_LSB];
    assign if_tag = if_pc[TAG_MSB:TAG_LSB];
    assign ex_idx = ex_pc[TAG_LSB-1:BP_PC_LSB];
    assign ex_tag = ex_pc[TAG_MSB:TAG_LSB];
    assign unused_pc_bits = ^{if_pc[31:TAG_MSB+1], if_pc[1:0],
                              ex_pc[31:TAG_MSB+1], ex_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= BP_ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            BP_ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == INDEX_W'(ENTRIES - 1)) state_d = BP_ST_RUN;
            end
            BP_ST_RUN: ;
            default: state_d = BP_ST_INIT;
        endcase
    end

    assign busy = (state_q == BP_ST_INIT);

    // Stale table contents during the sweep must never produce a taken prediction.
    assign lk_taken = if_req && (state_q == BP_ST_RUN) && valid_q[if_idx]
                      && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= if_req;
            pred_taken_q  <= lk_taken;
            pred_target_q <= lk_taken ? target_q[if_idx] : 32'h0;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    bp_sat_cnt2 u_sat_cnt (
        .cnt_in  (cnt_q[ex_idx]),
        .taken   (ex_act_taken),
        .cnt_out (cnt_next)
    );

    // Table arrays are not reset; the INIT sweep invalidates them instead.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == BP_ST_INIT) begin
                valid_q[init_ptr_q] <= 1'b0;
            end else if (ex_update) begin
                if (ex_hit) begin
                    cnt_q[ex_idx] <= cnt_next;
                end else begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    cnt_q[ex_idx]   <= ex_act_taken ? CNT_INIT_T : CNT_INIT_NT;
                end
                if (ex_act_taken) target_q[ex_idx] <= ex_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// against a table model built from integer counters and plain arrays.
module tb_branch_pred_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_act_taken;
    logic [31:0] ex_target;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bit          m_valid  [64];
    int          m_tag    [64];
    int          m_cnt    [64];
    logic [31:0] m_target [64];
    int          m_init_left;

    branch_pred_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .if_req       (if_req),
        .if_pc        (if_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .ex_update    (ex_update),
        .ex_pc        (ex_pc),
        .ex_act_taken (ex_act_taken),
        .ex_target    (ex_target),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int pcIndex(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int pcTag(input logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_init_left = 64;
    endtask

    // One clock of traffic: predict from the table as it stands, then retrain it.
    task automatic applyStimulus(input string name, input logic req, input logic [31:0] pc,
                                 input logic upd, input logic [31:0] epc,
                                 input logic tk, input logic [31:0] tgt);
        logic        exp_taken;
        logic [31:0] exp_target;
        int          i, t;
        if_req       = req;
        if_pc        = pc;
        ex_update    = upd;
        ex_pc        = epc;
        ex_act_taken = tk;
        ex_target    = tgt;

        i = pcIndex(pc);
        exp_taken  = req && (m_init_left == 0) && m_valid[i]
                     && (m_tag[i] == pcTag(pc)) && (m_cnt[i] >= 2);
        exp_target = exp_taken ? m_target[i] : 32'h0;

        if (m_init_left > 0) begin
            m_init_left--;
        end else if (upd) begin
            i = pcIndex(epc);
            t = pcTag(epc);
            if (m_valid[i] && m_tag[i] == t) begin
                m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_cnt[i]   = tk ? 2 : 1;
            end
            if (tk) m_target[i] = tgt;
        end

        @(posedge clk);
        #1;
        checkOutput({name, ".valid"},  32'(pred_valid),  32'(req));
        checkOutput({name, ".taken"},  32'(pred_taken),  32'(exp_taken));
        checkOutput({name, ".target"}, pred_target,      exp_target);
        checkOutput({name, ".busy"},   32'(busy),        32'(m_init_left > 0));
    endtask

    task automatic doReset(input string name, input logic req);
        resetn    = 1'b0;
        if_req    = req;
        if_pc     = 32'h0040_0010;
        ex_update = 1'b1;
        ex_pc     = 32'h0040_0010;
        ex_act_taken = 1'b1;
        ex_target = 32'h1234_5678;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput({name, ".busy"},   32'(busy),       32'd1);
        checkOutput({name, ".valid"},  32'(pred_valid), 32'd0);
        checkOutput({name, ".taken"},  32'(pred_taken), 32'd0);
        checkOutput({name, ".target"}, pred_target,     32'h0);
        resetn    = 1'b1;
        if_req    = 1'b0;
        ex_update = 1'b0;
    endtask

    task automatic waitInit(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            applyStimulus("init", (n == 0), 32'h0040_0000, 1'b0, 32'h0, 1'b0, 32'h0);
            n++;
        end
        checkOutput(name, 32'(n), 32'd64);
    endtask

    initial begin
        logic [31:0] rpc, repc;
        resetn = 1'b0; if_req = 1'b0; if_pc = '0; ex_update = 1'b0;
        ex_pc = '0; ex_act_taken = 1'b0; ex_target = '0;
        #1;

        doReset("reset", 1'b0);
        waitInit("init_len");

        applyStimulus("train",   1'b0, 32'h0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100);
        applyStimulus("hit",     1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("hit.direct_target", pred_target, 32'h0040_0100);

        for (int k = 0; k < 4; k++)
            applyStimulus("nt_dec", 1'b0, 32'h0, 1'b1, 32'h0040_0010, 1'b0, 32'h0);
        applyStimulus("sat_low", 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("sat_low.direct", 32'(pred_taken), 32'd0);
        for (int k = 0; k < 2; k++)
            applyStimulus("t_inc", 1'b0, 32'h0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100);
        applyStimulus("retaken", 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("retaken.direct", 32'(pred_taken), 32'd1);

        applyStimulus("alias_nt", 1'b0, 32'h0, 1'b1, 32'h0040_1010, 1'b0, 32'h0);
        applyStimulus("alias_lk", 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("alias.direct", 32'(pred_taken), 32'd0);

        applyStimulus("coll_same", 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200);
        checkOutput("coll.direct", 32'(pred_taken), 32'd0);
        applyStimulus("coll_next", 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("coll_next.direct", 32'(pred_taken), 32'd1);

        applyStimulus("pre_rst", 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        doReset("mid_reset", 1'b1);
        waitInit("mid_init_len");
        applyStimulus("post_rst", 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("post_rst.direct", 32'(pred_taken), 32'd0);

        for (int k = 0; k < 3000; k++) begin
            rpc  = ($urandom << 16) | (32'($urandom_range(0, 2)) << 8)
                   | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            repc = ($urandom << 16) | (32'($urandom_range(0, 2)) << 8)
                   | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                doReset("rnd_reset", 1'($urandom));
            end else begin
                applyStimulus("rnd", 1'($urandom), rpc, 1'($urandom_range(0, 2) != 0),
                              repc, 1'($urandom), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
